// File: rtl/clk_freq_monitor.sv
// clk_freq_monitor
//   Measures a generated clock against the reference clock. Rising edges of
//   meas_clk_in are counted over a gate window of GATE_CYCLES reference
//   cycles and compared against EXP_COUNT +/- TOL. After LOCK_WINDOWS
//   consecutive passing windows, with the wizard reporting lock, freq_ok is
//   raised. An out-of-tolerance window sets the sticky freq_err.
//
// Ports
//   clk_0        in   reference clock; all logic on its rising edge
//   rst_0        in   asynchronous active-low reset
//   meas_clk_in  in   clock under test (asynchronous, sampled as data)
//   locked_in    in   wizard lock indication (asynchronous)
//   enable       in   synchronous run enable
//   err_clr      in   synchronous clear of freq_err
//   edge_count   out  edge count of the last completed window
//   count_valid  out  one-cycle pulse when edge_count updates
//   freq_ok      out  qualified frequency-good flag
//   freq_err     out  sticky out-of-tolerance flag
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE      | disabled, counters and qualification cleared
// WAIT_LOCK | enabled, waiting for synchronized lock
// MEASURE   | gate window running, counting edges
// EVAL      | one cycle: publish count, judge window, restart gate

module clk_freq_monitor #(
  parameter int GATE_CYCLES  = 1000,
  parameter int EXP_COUNT    = 100,
  parameter int TOL          = 2,
  parameter int LOCK_WINDOWS = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk_0,
  input  logic             rst_0,
  input  logic             meas_clk_in,
  input  logic             locked_in,
  input  logic             enable,
  input  logic             err_clr,
  output logic [CNT_W-1:0] edge_count,
  output logic             count_valid,
  output logic             freq_ok,
  output logic             freq_err
);

  localparam int GOOD_W = $clog2(LOCK_WINDOWS + 1);

  localparam logic [CNT_W-1:0]  GATE_LAST = CNT_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W:0]    EXP_EXT   = (CNT_W + 1)'(EXP_COUNT);
  localparam logic [CNT_W:0]    TOL_EXT   = (CNT_W + 1)'(TOL);
  localparam logic [GOOD_W-1:0] GOOD_MAX  = GOOD_W'(LOCK_WINDOWS);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LOCK = 2'd1,
    MEASURE   = 2'd2,
    EVAL      = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic meas_s1_q, meas_s2_q, meas_hist_q;
  logic lock_s1_q, lock_s2_q;

  logic [CNT_W-1:0]  gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
  logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
  logic [CNT_W-1:0]  edge_count_q, edge_count_d;
  logic              count_valid_q, count_valid_d;
  logic              freq_ok_q, freq_ok_d;
  logic              freq_err_q, freq_err_d;

  logic             edge_det;
  logic             lock_s;
  logic [CNT_W:0]   edge_ext;
  logic [CNT_W:0]   diff;
  logic             win_pass;

  // Input conditioning: two-flop synchronizers, plus a history flop on the
  // measured clock so a rising edge is seen as sync2=1, hist=0.
  always_ff @(posedge clk_0 or negedge rst_0) begin
    if (!rst_0) begin
      meas_s1_q   <= 1'b0;
      meas_s2_q   <= 1'b0;
      meas_hist_q <= 1'b0;
      lock_s1_q   <= 1'b0;
      lock_s2_q   <= 1'b0;
    end else begin
      meas_s1_q   <= meas_clk_in;
      meas_s2_q   <= meas_s1_q;
      meas_hist_q <= meas_s2_q;
      lock_s1_q   <= locked_in;
      lock_s2_q   <= lock_s1_q;
    end
  end

  assign edge_det = meas_s2_q & ~meas_hist_q;
  assign lock_s   = lock_s2_q;

  // Absolute deviation one bit wider than the counter so it cannot wrap.
  assign edge_ext = {1'b0, edge_cnt_q};
  assign diff     = (edge_ext >= EXP_EXT) ? (edge_ext - EXP_EXT) : (EXP_EXT - edge_ext);
  assign win_pass = (diff <= TOL_EXT);

  always_comb begin
    state_d       = state_q;
    gate_cnt_d    = gate_cnt_q;
    edge_cnt_d    = edge_cnt_q;
    good_cnt_d    = good_cnt_q;
    edge_count_d  = edge_count_q;
    count_valid_d = 1'b0;
    freq_err_d    = freq_err_q;

    // Clear first so a failing EVAL below overrides it in the same cycle.
    if (err_clr) freq_err_d = 1'b0;

    if (!enable) begin
      state_d    = IDLE;
      gate_cnt_d = '0;
      edge_cnt_d = '0;
      good_cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          good_cnt_d = '0;
          state_d    = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          if (lock_s) state_d = MEASURE;
        end
        MEASURE: begin
          if (!lock_s) begin
            gate_cnt_d = '0;
            edge_cnt_d = '0;
            good_cnt_d = '0;
            state_d    = WAIT_LOCK;
          end else begin
            gate_cnt_d = gate_cnt_q + 1'b1;
            if (edge_det && (edge_cnt_q != CNT_MAX)) edge_cnt_d = edge_cnt_q + 1'b1;
            if (gate_cnt_q == GATE_LAST) state_d = EVAL;
          end
        end
        EVAL: begin
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          if (!lock_s) begin
            // Lock lost: the window is dropped without publishing a count.
            good_cnt_d = '0;
            state_d    = WAIT_LOCK;
          end else begin
            edge_count_d  = edge_cnt_q;
            count_valid_d = 1'b1;
            if (win_pass) begin
              if (good_cnt_q != GOOD_MAX) good_cnt_d = good_cnt_q + 1'b1;
            end else begin
              good_cnt_d = '0;
              freq_err_d = 1'b1;
            end
            state_d = MEASURE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    freq_ok_d = (good_cnt_d == GOOD_MAX) && ((state_d == MEASURE) || (state_d == EVAL));
  end

  always_ff @(posedge clk_0 or negedge rst_0) begin
    if (!rst_0) begin
      state_q       <= IDLE;
      gate_cnt_q    <= '0;
      edge_cnt_q    <= '0;
      good_cnt_q    <= '0;
      edge_count_q  <= '0;
      count_valid_q <= 1'b0;
      freq_ok_q     <= 1'b0;
      freq_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      gate_cnt_q    <= gate_cnt_d;
      edge_cnt_q    <= edge_cnt_d;
      good_cnt_q    <= good_cnt_d;
      edge_count_q  <= edge_count_d;
      count_valid_q <= count_valid_d;
      freq_ok_q     <= freq_ok_d;
      freq_err_q    <= freq_err_d;
    end
  end

  assign edge_count  = edge_count_q;
  assign count_valid = count_valid_q;
  assign freq_ok     = freq_ok_q;
  assign freq_err    = freq_err_q;

endmodule

// File: tb/tb_clk_freq_monitor.sv
// Bench for clk_freq_monitor: 100 MHz reference, generated measured clock
// with selectable (and randomized) integer-ns period, offset off the
// reference edges. Expectations come from window arithmetic (edges that fit
// in GATE_CYCLES*10 ns) and a pass/qualify/sticky-error model.
`timescale 1ns/1ps

module tb_clk_freq_monitor;

  localparam int G      = 1000;
  localparam int EXP    = 100;
  localparam int TOL    = 2;
  localparam int LW     = 4;
  localparam int CW     = 16;
  localparam int WIN_NS = G * 10;

  logic          clk_0       = 1'b0;
  logic          rst_0       = 1'b0;
  logic          meas_clk_in = 1'b0;
  logic          locked_in   = 1'b0;
  logic          enable      = 1'b0;
  logic          err_clr     = 1'b0;
  logic [CW-1:0] edge_count;
  logic          count_valid;
  logic          freq_ok;
  logic          freq_err;

  int      checks = 0;
  int      errors = 0;
  int      meas_per = 100;
  bit      meas_run = 1'b0;
  int      m_good = 0;
  bit      m_err = 1'b0;
  int      m_last_ec = 0;
  realtime last_cv_t = 0.0;

  clk_freq_monitor #(
    .GATE_CYCLES (G),
    .EXP_COUNT   (EXP),
    .TOL         (TOL),
    .LOCK_WINDOWS(LW),
    .CNT_W       (CW)
  ) dut (
    .clk_0      (clk_0),
    .rst_0      (rst_0),
    .meas_clk_in(meas_clk_in),
    .locked_in  (locked_in),
    .enable     (enable),
    .err_clr    (err_clr),
    .edge_count (edge_count),
    .count_valid(count_valid),
    .freq_ok    (freq_ok),
    .freq_err   (freq_err)
  );

  always #5 clk_0 = ~clk_0;

  // Edges land on x.3 / x.8 ns, never on a reference edge at multiples of 5.
  initial begin
    #0.3;
    forever begin
      if (meas_run) begin
        meas_clk_in = 1'b1;
        #(meas_per * 0.5);
        meas_clk_in = 1'b0;
        #(meas_per * 0.5);
      end else begin
        meas_clk_in = 1'b0;
        #1;
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog sim time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic wait_cv(input int budget, output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    while (n < budget && !ok) begin
      @(negedge clk_0);
      n++;
      if (count_valid) ok = 1'b1;
    end
    if (!ok) check_eq("cv_timeout", count_valid, 1);
  endtask

  task automatic watch_no_cv(input int cycles, input string tag);
    bit seen;
    seen = 1'b0;
    repeat (cycles) begin
      @(negedge clk_0);
      if (count_valid) seen = 1'b1;
    end
    check_eq(tag, seen, 0);
  endtask

  // One window: latency/spacing against t_ref, edge count against the
  // number of periods that fit in the gate, then pass/qualify/error model.
  task automatic do_window(input bit rng, input int lo_n, input int hi_n, input realtime t_ref);
    bit ok;
    int sp, ec, lo, hi, d;
    wait_cv(G + 10, ok);
    if (!ok) return;
    if (lo_n > 0) begin
      sp = int'(($realtime - t_ref) / 10.0);
      check_eq("cv_timing", sp, (sp < lo_n) ? lo_n : ((sp > hi_n) ? hi_n : sp));
    end
    last_cv_t = $realtime;
    ec = int'(edge_count);
    if (rng) begin
      if (meas_run) begin
        lo = (WIN_NS + meas_per - 1) / meas_per - 1;
        hi = WIN_NS / meas_per + 1;
      end else begin
        lo = 0;
        hi = 0;
      end
      check_eq("edge_count", ec, (ec < lo) ? lo : ((ec > hi) ? hi : ec));
    end
    d = (ec > EXP) ? (ec - EXP) : (EXP - ec);
    if (d <= TOL) begin
      if (m_good < LW) m_good++;
    end else begin
      m_good = 0;
      m_err  = 1'b1;
    end
    m_last_ec = ec;
    check_eq("freq_ok", freq_ok, (m_good == LW) ? 1 : 0);
    check_eq("freq_err", freq_err, m_err ? 1 : 0);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk_0);
    err_clr = 1'b0;
    m_err   = 1'b0;
    check_eq("err_clr", freq_err, 0);
  endtask

  initial begin
    realtime t;
    int k;

    // Reset values
    repeat (3) @(negedge clk_0);
    check_eq("rst_edge_count", edge_count, 0);
    check_eq("rst_count_valid", count_valid, 0);
    check_eq("rst_freq_ok", freq_ok, 0);
    check_eq("rst_freq_err", freq_err, 0);
    rst_0 = 1'b1;

    // Nominal: 100 ns, enable early, lock at ~1 us
    meas_per = 100;
    meas_run = 1'b1;
    @(negedge clk_0);
    enable = 1'b1;
    while ($realtime < 1000.0) @(negedge clk_0);
    locked_in = 1'b1;
    t = $realtime;
    do_window(1, G + 3, G + 4, t);
    repeat (4) do_window(1, G + 1, G + 1, last_cv_t);

    // Enable drop holds edge_count / freq_err, clears freq_ok
    enable = 1'b0;
    @(negedge clk_0);
    check_eq("dis_freq_ok", freq_ok, 0);
    check_eq("dis_edge_hold", edge_count, m_last_ec);
    check_eq("dis_err_hold", freq_err, m_err ? 1 : 0);
    watch_no_cv(20, "dis_no_cv");
    m_good = 0;
    enable = 1'b1;
    t = $realtime;
    do_window(1, G + 3, G + 3, t);

    // Fast clock fails, then clear and recover at 100 ns
    meas_per = 90;
    do_window(0, G + 1, G + 1, last_cv_t);
    do_window(1, G + 1, G + 1, last_cv_t);
    check_eq("fast_err", freq_err, 1);
    meas_per = 100;
    pulse_clr();
    do_window(0, G + 1, G + 1, last_cv_t);
    repeat (4) do_window(1, G + 1, G + 1, last_cv_t);

    // Tolerance edge: 98 ns near upper bound, 97 ns over it
    meas_per = 98;
    do_window(0, G + 1, G + 1, last_cv_t);
    do_window(1, G + 1, G + 1, last_cv_t);
    meas_per = 97;
    do_window(0, G + 1, G + 1, last_cv_t);
    do_window(1, G + 1, G + 1, last_cv_t);
    check_eq("tol97_err", freq_err, 1);
    check_eq("tol97_ok", freq_ok, 0);
    meas_per = 100;
    pulse_clr();
    do_window(0, G + 1, G + 1, last_cv_t);
    repeat (4) do_window(1, G + 1, G + 1, last_cv_t);

    // Lock loss mid-window after qualification
    repeat (400) @(negedge clk_0);
    locked_in = 1'b0;
    k = 0;
    do begin
      @(negedge clk_0);
      k++;
    end while (freq_ok && k < 3);
    check_eq("lockloss_freq_ok", freq_ok, 0);
    watch_no_cv(1500, "lockloss_no_cv");
    m_good = 0;
    locked_in = 1'b1;
    t = $realtime;
    do_window(1, G + 3, G + 4, t);
    repeat (3) do_window(1, G + 1, G + 1, last_cv_t);

    // Reset mid-MEASURE
    repeat (300) @(negedge clk_0);
    #2;
    rst_0 = 1'b0;
    #0.1;
    check_eq("midrst_edge_count", edge_count, 0);
    check_eq("midrst_count_valid", count_valid, 0);
    check_eq("midrst_freq_ok", freq_ok, 0);
    check_eq("midrst_freq_err", freq_err, 0);
    enable = 1'b0;
    @(negedge clk_0);
    rst_0  = 1'b1;
    m_good = 0;
    m_err  = 1'b0;
    watch_no_cv(1500, "idle_no_cv");
    check_eq("idle_freq_ok", freq_ok, 0);

    // Stuck clock, then err_clr coinciding with a failing EVAL
    meas_run = 1'b0;
    @(negedge clk_0);
    enable = 1'b1;
    t = $realtime;
    do_window(1, G + 3, G + 3, t);
    pulse_clr();
    repeat (G - 1) @(negedge clk_0);
    err_clr = 1'b1;
    do_window(1, G + 1, G + 1, last_cv_t);
    err_clr = 1'b0;
    @(negedge clk_0);
    check_eq("clr_vs_fail", freq_err, 1);

    // Randomized periods with occasional error clears
    meas_run = 1'b1;
    pulse_clr();
    for (int it = 0; it < 6; it++) begin
      meas_per = int'($urandom_range(94, 106));
      do_window(0, 0, 0, last_cv_t);
      do_window(1, G + 1, G + 1, last_cv_t);
      if ($urandom_range(0, 1) == 1) pulse_clr();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_freq_monitor.md
# clk_freq_monitor

Frequency and lock checker for the clocking subsystem's generated clocks. It runs on the 100 MHz reference clock and samples a generated clock, typically the 10 MHz output, as an asynchronous data input. It counts that clock's rising edges over a fixed gate window of reference cycles and checks the count against an expected value. Once enough consecutive windows pass while the wizard reports lock, it asserts a qualified "frequency good" flag for downstream logic and for bench self-checking.

## Interface
Parameters:
- GATE_CYCLES, 1000: reference-clock cycles per measurement window.
- EXP_COUNT, 100: expected rising edges per window (10 MHz against 100 MHz).
- TOL, 2: allowed absolute deviation from EXP_COUNT, inclusive.
- LOCK_WINDOWS, 4: consecutive passing windows required to assert freq_ok.
- CNT_W, 16: width of the edge and gate counters.

Ports:
- clk_0  in  1  reference clock, 100 MHz; all logic is on its rising edge.
- rst_0  in  1  asynchronous, active-low reset.
- meas_clk_in  in  1  clock under test, asynchronous to clk_0.
- locked_in  in  1  lock indication from the clock wizard, asynchronous.
- enable  in  1  synchronous run enable.
- err_clr  in  1  synchronous pulse that clears freq_err.
- edge_count  out  CNT_W  edge count of the last completed window.
- count_valid  out  1  one-cycle pulse when edge_count updates.
- freq_ok  out  1  qualified frequency-good flag.
- freq_err  out  1  sticky out-of-tolerance flag.

## Operation
Input conditioning:
- meas_clk_in passes through a 2-FF synchronizer plus one history FF.
- An edge is counted when sync2 = 1 and hist = 0.
- locked_in passes through a 2-FF synchronizer, giving lock_s.

State machine:
- IDLE
  - Counters cleared, freq_ok = 0.
  - Goes to WAIT_LOCK when enable = 1.
- WAIT_LOCK
  - Counters held at 0.
  - Goes to MEASURE when lock_s = 1.
- MEASURE
  - gate_cnt increments every cycle.
  - edge_cnt increments on each detected edge and saturates at 2^CNT_W−1.
  - Goes to EVAL on the cycle where gate_cnt = GATE_CYCLES−1.
- EVAL (one cycle)
  - edge_count ← edge_cnt; count_valid = 1.
  - Pass when |edge_cnt − EXP_COUNT| ≤ TOL. Compute the difference without wrap, using a width of CNT_W+1.
  - On pass: good_cnt increments, saturating at LOCK_WINDOWS.
  - On fail: good_cnt ← 0, freq_err ← 1.
  - gate_cnt and edge_cnt clear; any edge detected in this cycle is discarded.
  - Goes back to MEASURE.

Flags:
- freq_ok = 1 exactly when good_cnt = LOCK_WINDOWS and the state is MEASURE or EVAL.

Boundary conditions:
- lock_s falls in MEASURE or EVAL:
  - Abort the window with no count_valid.
  - Clear good_cnt and freq_ok; clear gate_cnt and edge_cnt.
  - Go to WAIT_LOCK.
- enable = 0 in any state:
  - Go to IDLE next cycle; freq_ok ← 0, good_cnt ← 0.
  - edge_count and freq_err are held.
- err_clr in the same cycle as a failing EVAL: set wins, so freq_err stays 1.
- err_clr at any other time clears freq_err on the next cycle.
- Reset asserted mid-window: every register clears immediately and the state becomes IDLE.

## Timing
- Reset values:
  - edge_count = 0, count_valid = 0, freq_ok = 0, freq_err = 0.
  - State = IDLE; all internal counters = 0.
- locked_in to state change: 2–3 clk_0 cycles (synchronizer delay).
- meas_clk_in edge to edge_cnt increment: 3 cycles.
- MEASURE lasts exactly GATE_CYCLES cycles; EVAL lasts 1 cycle.
- Window period is therefore GATE_CYCLES+1 cycles, and count_valid pulses every GATE_CYCLES+1 cycles while locked.
- First count_valid comes GATE_CYCLES+1 cycles after entering MEASURE.
- freq_ok rises in the cycle after the LOCK_WINDOWS-th consecutive passing EVAL.
- freq_ok falls within 3 cycles of locked_in deasserting, or in the cycle after a failing EVAL.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Nominal:** meas 10 MHz (100 ns period), locked_in = 1 at 1 µs, enable = 1.
  - edge_count = 100 (±1, phase-dependent) on every count_valid.
  - freq_ok = 1 after the 4th count_valid; freq_err = 0.
- **Fast clock:** meas period 90 ns.
  - edge_count = 111 and freq_err = 1 after the first window; freq_ok stays 0.
  - Pulse err_clr, then switch to 100 ns: freq_err = 0 next cycle, freq_ok = 1 after 4 windows.
- **Tolerance edge:**
  - Period 98 ns gives edge_count = 102: pass.
  - Period 97 ns gives edge_count = 103: freq_err = 1 and good_cnt resets.
- **Lock loss:** drop locked_in mid-window after freq_ok = 1.
  - freq_ok = 0 within 3 cycles; no count_valid for that window.
  - On relock, freq_ok returns only after 4 new passing windows.
- **Reset and enable:** assert rst_0 = 0 mid-MEASURE.
  - All outputs are 0 in the same time step.
  - After release with enable = 0, the state stays IDLE and no count_valid appears.
- **Stuck clock:** hold meas_clk_in = 0.
  - edge_count = 0 and freq_err = 1 at the first EVAL.
  - A simultaneous err_clr leaves freq_err = 1.
